// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   ACC_WORD         : memory access size code for a 32-bit word
//   fetch_entry_t    : prefetch buffer entry {pc, instr} at default widths
package fetch_pkg;

  localparam int unsigned PC_W_DEFAULT    = 32;
  localparam int unsigned INSTR_W_DEFAULT = 32;

  localparam logic [PC_W_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h8002_0000;
  localparam logic [1:0]              ACC_WORD         = 2'b00;

  typedef struct packed {
    logic [PC_W_DEFAULT-1:0]    pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush and occupancy count.
//   clk, rst_n          : clock, async active-low reset
//   flush               : empty the FIFO (overrides push/pop)
//   push, push_data     : write an entry (caller guarantees not full)
//   pop                 : remove the head entry (ignored when empty)
//   pop_data            : current head entry
//   count               : number of stored entries (0..DEPTH)
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_eff;

  assign pop_eff  = pop && (count != '0);
  assign pop_data = storage[rd_ptr];

  // Data array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_eff);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches, buffers the
// in-order responses and presents them to decode; redirects flush the buffer
// and discard responses still in flight. DEPTH must be a power of 2, >= 2.
//   clk, rst_n                    : clock, async active-low reset
//   stall                         : decode cannot take the head this cycle
//   redirect, redirect_addr       : jump/taken branch and its target
//   mem_req, mem_addr, mem_ready  : fetch request handshake
//   mem_rvalid, mem_rdata         : in-order read response
//   rw, acc_size                  : constant read / word access
//   inst_valid, inst_data, inst_pc: buffer head presented to decode
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned        DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               rw,
  output logic [1:0]         acc_size,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  resp_pc;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     credit_used;
  logic [ADDR_W-1:0]  target_pc;
  logic               accept;
  logic               push;
  logic               drop;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               unused_addr_bits;

  assign target_pc        = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Credit: every outstanding request owns a buffer slot, so a push never
  // finds the buffer full.
  assign credit_used = {1'b0, inflight} + {1'b0, count};
  assign mem_req     = !redirect && (credit_used < (CNT_W+1)'(DEPTH));
  assign mem_addr    = fetch_pc;
  assign accept      = mem_req && mem_ready;

  // A response arriving with a redirect belongs to the old stream.
  assign drop = mem_rvalid && !redirect && (drop_cnt != '0);
  assign push = mem_rvalid && !redirect && (drop_cnt == '0);
  assign pop  = inst_valid && !stall && !redirect;

  assign rw       = 1'b0;
  assign acc_size = ACC_WORD;

  // Fetch and response PCs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        resp_pc <= resp_pc + ADDR_W'(4);
      end
    end
  end

  // Outstanding requests and stale responses still to be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(mem_rvalid);
      if (redirect) begin
        drop_cnt <= inflight - CNT_W'(mem_rvalid);
      end else if (drop) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({resp_pc, mem_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_pc    = head[ENTRY_W-1:INSTR_W];
  assign inst_data  = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios followed by a
// randomized run, all checked against a stream-level reference model.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rw;
  logic [1:0]  acc_size;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  fetch_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rw            (rw),
    .acc_size      (acc_size),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  // Memory request record: address, stream epoch at issue, cycle data is due.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t         mq[$];
  fetch_entry_t bufq[$];
  logic [31:0]  fpc;
  int           epoch;
  int           cyc;
  int           lat_min;
  int           lat_max;

  int tests;
  int fails;

  logic [31:0] acc_log[$];
  int          first_acc;
  int          first_valid;
  logic [31:0] first_valid_pc;
  int          pop_cnt;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic s, input logic r, input logic [31:0] ra, input logic rdy);
    logic   rv;
    logic   exp_req;
    logic   acc;
    logic   pop;
    req_t   e;
    fetch_entry_t ent;
    stall         = s;
    redirect      = r;
    redirect_addr = ra;
    mem_ready     = rdy;
    rv            = (mq.size() != 0) && (mq[0].due <= cyc);
    mem_rvalid    = rv;
    mem_rdata     = rv ? mem_word(mq[0].addr) : 32'h0;
    #4;
    assert (!(mem_rvalid && mq.size() == 0))
      else $error("FAIL rvalid_without_inflight");

    exp_req = !r && ((mq.size() + bufq.size()) < DEPTH);
    chk("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) chk("mem_addr", 64'(mem_addr), 64'(fpc));
    chk("inst_valid", 64'(inst_valid), 64'(bufq.size() != 0));
    if (bufq.size() != 0) begin
      chk("inst_pc", 64'(inst_pc), 64'(bufq[0].pc));
      chk("inst_data", 64'(inst_data), 64'(bufq[0].instr));
    end
    chk("rw", 64'(rw), 64'd0);
    chk("acc_size", 64'(acc_size), 64'd0);

    if (mem_req && mem_ready) begin
      acc_log.push_back(mem_addr);
      if (first_acc < 0) first_acc = cyc;
    end
    if (inst_valid && first_valid < 0) begin
      first_valid    = cyc;
      first_valid_pc = inst_pc;
    end
    if (inst_valid && !s && !r) pop_cnt++;
    last_req  = mem_req;
    last_addr = mem_addr;

    acc = exp_req && rdy;
    pop = (bufq.size() != 0) && !s && !r;
    e   = '{addr: 32'h0, epoch: -1, due: 0};
    if (rv) e = mq.pop_front();
    if (r) begin
      bufq.delete();
      epoch++;
      fpc = {ra[31:2], 2'b00};
    end else begin
      if (pop) void'(bufq.pop_front());
      if (rv && e.epoch == epoch) begin
        ent.pc    = e.addr;
        ent.instr = mem_word(e.addr);
        bufq.push_back(ent);
      end
    end
    if (acc) begin
      mq.push_back('{addr: fpc, epoch: epoch, due: cyc + int'($urandom_range(lat_max, lat_min))});
      fpc = fpc + 32'd4;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset the block and the memory together, abandoning anything in flight.
  task automatic do_reset();
    rst_n      = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    mq.delete();
    bufq.delete();
    fpc = RST_PC;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; epoch = 0;
    lat_min = 1; lat_max = 1;
    first_acc = -1; first_valid = -1; first_valid_pc = '0; pop_cnt = 0;
    last_req = 1'b0; last_addr = '0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    fpc = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_inst_valid", 64'(inst_valid), 64'd0);
    rst_n = 1'b1;

    // Reset release, ready memory with 1-cycle latency.
    acc_log.delete(); first_acc = -1; first_valid = -1;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("seq_addr0", 64'(acc_log[0]), 64'h8002_0000);
    chk("seq_addr1", 64'(acc_log[1]), 64'h8002_0004);
    chk("seq_addr2", 64'(acc_log[2]), 64'h8002_0008);
    chk("seq_addr3", 64'(acc_log[3]), 64'h8002_000C);
    chk("first_valid_latency", 64'(first_valid - first_acc), 64'd2);
    chk("first_valid_pc", 64'(first_valid_pc), 64'h8002_0000);

    // Stall held: buffer fills to DEPTH, then issue stops; release drains.
    do_reset();
    acc_log.delete();
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_accepts", 64'(acc_log.size()), 64'(DEPTH));
    chk("stall_req_low", 64'(last_req), 64'd0);
    pop_cnt = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_pops", 64'(pop_cnt), 64'd4);
    chk("issue_resumed", 64'(acc_log.size() > DEPTH), 64'd1);

    // Redirect with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("two_inflight", 64'(mq.size()), 64'd2);
    step(1'b0, 1'b1, 32'h0000_1003, 1'b1);
    first_valid = -1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_addr", 64'(last_addr), 64'h0000_1000);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_first_pc", 64'(first_valid_pc), 64'h0000_1000);

    // Redirect in the same cycle as the only outstanding response.
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    first_valid = -1;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("coincide_first_pc", 64'(first_valid_pc), 64'h0000_2000);

    // Address wrap at the top of the space.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_top", 64'(last_addr), 64'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_zero", 64'(last_addr), 64'h0000_0000);

    // Reset with requests in flight and the buffer non-empty.
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("pre_reset_inflight", 64'(mq.size()), 64'd3);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_reset_addr", 64'(last_addr), 64'(RST_PC));

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic [31:0] ra;
      r  = ($urandom_range(99, 0) < 5);
      ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                       : 32'($urandom);
      step($urandom_range(99, 0) < 30, r, ra, $urandom_range(99, 0) < 70);
      if (i == 700) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8002_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the PC and memory address width.
REQ-003 The block SHALL have parameter INSTR_W, default 32, meaning the instruction word width.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries; it SHALL be a power of 2 and at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port stall, input, 1 bit: decode cannot accept an instruction this cycle.
REQ-008 The block SHALL have port redirect, input, 1 bit: a jump or taken branch.
REQ-009 The block SHALL have port redirect_addr, input, ADDR_W bits: the redirect target.
REQ-010 The block SHALL have port mem_req, output, 1 bit: fetch request valid.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W bits: the request address.
REQ-012 The block SHALL have port mem_ready, input, 1 bit: memory accepts the request.
REQ-013 The block SHALL have port mem_rvalid, input, 1 bit: read data valid; responses return in order.
REQ-014 The block SHALL have port mem_rdata, input, INSTR_W bits: the read data.
REQ-015 The block SHALL have port rw, output, 1 bit: constant 0 (read).
REQ-016 The block SHALL have port acc_size, output, 2 bits: constant 2'b00 (word).
REQ-017 The block SHALL have port inst_valid, output, 1 bit: the buffer head is valid.
REQ-018 The block SHALL have port inst_data, output, INSTR_W bits: the head instruction.
REQ-019 The block SHALL have port inst_pc, output, ADDR_W bits: the head instruction's PC.

Function
REQ-020 The block SHALL accept a request in any cycle where mem_req && mem_ready; on acceptance fetch_pc SHALL advance by 4, wrapping modulo 2^ADDR_W.
REQ-021 mem_req SHALL equal (!redirect && inflight + count < DEPTH); mem_addr SHALL equal fetch_pc.
REQ-022 inflight SHALL increment on acceptance, decrement on mem_rvalid, and stay unchanged when both occur in the same cycle.
REQ-023 On mem_rvalid with drop_cnt>0, the block SHALL discard the response and decrement drop_cnt; otherwise it SHALL push {resp_pc, mem_rdata} into the buffer and advance resp_pc by 4.
REQ-024 The credit rule SHALL guarantee inflight + count <= DEPTH at all times, so a push never meets a full buffer.
REQ-025 inst_valid SHALL equal (count != 0); the block SHALL pop when inst_valid && !stall, and push and pop SHALL coexist in the same cycle.
REQ-026 Latency SHALL have no bypass: a request accepted in cycle N with rvalid in N+1 SHALL give inst_valid at N+2 at the earliest.
REQ-027 On redirect, fetch_pc and resp_pc SHALL load {redirect_addr[ADDR_W-1:2], 2'b00} and the buffer SHALL flush.
REQ-028 On redirect, drop_cnt SHALL load inflight - mem_rvalid; a pop in that cycle SHALL have no effect.
REQ-029 Redirect SHALL take priority over stall, and stall SHALL NOT block issue.
REQ-030 A second redirect while drop_cnt>0 SHALL reload drop_cnt using the same formula.
REQ-031 mem_rvalid with inflight==0 is illegal and SHALL be flagged by a bench assertion.

Reset
REQ-032 While rst_n=0, the block SHALL hold fetch_pc=resp_pc=RESET_PC, count=inflight=drop_cnt=0, and inst_valid=0; reset applies asynchronously.
REQ-033 mem_req SHALL assert in the first cycle after rst_n rises, with mem_addr=RESET_PC.
REQ-034 Reset mid-operation SHALL abandon in-flight responses; memory is reset together with the block.

Structure
REQ-035 Package fetch_pkg SHALL hold the default RESET_PC, the ACC_WORD=2'b00 constant, and the fetch entry struct {pc, instr}.
REQ-036 The design SHALL use one sub-module, fetch_fifo: a synchronous FIFO parametrised by width and DEPTH, with a single-cycle flush and a count output.

Verification
REQ-037 The bench SHALL cover: reset release with mem_ready=1 and 1-cycle memory -> addresses 8002_0000, _0004, _0008, _000C issued; first inst_valid 2 cycles after first accept with inst_pc=8002_0000.
REQ-038 The bench SHALL cover: stall held high, DEPTH=4 -> exactly 4 accepts, then mem_req=0; after stall drops, one pop per cycle and issue resumes.
REQ-039 The bench SHALL cover: redirect to 0x0000_1003 with 2 in flight -> next mem_addr=0x0000_1000, two responses discarded, next inst_pc=0x0000_1000.
REQ-040 The bench SHALL cover: redirect coinciding with mem_rvalid and inflight=1 -> drop_cnt=0, and the response in that cycle is not buffered.
REQ-041 The bench SHALL cover: fetch_pc=FFFF_FFFC accepted -> next mem_addr=0000_0000.
REQ-042 The bench SHALL cover: rst_n asserted with 3 in flight -> inst_valid=0 immediately, and mem_addr=RESET_PC after release.
